// File: rtl/fifo_arb_pkg.sv
// Shared state type and round-robin helper for fifo_wr_arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_ID_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] id;
  } rr_result_t;

  // First set bit of valid_vec searching upward from last_id+1, wrapping at n_req.
  function automatic rr_result_t next_rr_id(input logic [MAX_REQ-1:0]  valid_vec,
                                            input logic [MAX_ID_W-1:0] last_id,
                                            input int                  n_req);
    rr_result_t res;
    int         idx;
    res = '0;
    for (int k = int'(MAX_REQ); k > 0; k--) begin
      if (k <= n_req) begin
        idx = (int'(last_id) + k) % n_req;
        if (valid_vec[idx[MAX_ID_W-1:0]]) begin
          res.found = 1'b1;
          res.id    = idx[MAX_ID_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: rotate by last_id+1, priority-encode, un-rotate.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  last_id_i,
  output logic             found_o,
  output logic [ID_W-1:0]  id_o
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  first_k;

  // base + offs never exceeds 2*N_REQ-1, so a single conditional subtract wraps it.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned      offs);
    int unsigned sum;
    sum = 32'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return ID_W'(sum);
  endfunction

  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rot[k] = valid_i[wrap_add(last_id_i, k + 1)];
    end
  end

  always_comb begin
    first_k = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) first_k = ID_W'(k);
    end
  end

  assign found_o = |rot;
  assign id_o    = wrap_add(last_id_i, 32'(first_k) + 1);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready burst sources.
// Define FIFO_ARB_BURST_LOCK_EN to hold a grant across req_valid gaps until last/MAX_BURST.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  output logic                        wr_en,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [N_REQ-1:0]            grant,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             accept;
  logic             gap_release;
  logic             release_burst;

  // While granted last_id_q equals grant_id_q, so one search start serves both states.
  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid_i   (req_valid),
    .last_id_i (last_id_q),
    .found_o   (pick_found),
    .id_o      (pick_id)
  );

  assign busy      = (state_q == ARB_GRANT);
  assign grant_id  = grant_id_q;
  assign grant     = busy ? (N_REQ'(1) << grant_id_q) : '0;
  assign accept    = busy & req_valid[grant_id_q] & ~full;
  assign wr_en     = accept;
  assign req_ready = accept ? (N_REQ'(1) << grant_id_q) : '0;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_BURST_LOCK_EN
  assign gap_release = 1'b0;
`else
  assign gap_release = busy & ~req_valid[grant_id_q];
`endif

  assign release_burst = (accept & (req_last[grant_id_q] |
                                    (beat_cnt_q == CNT_W'(MAX_BURST - 1)))) |
                         gap_release;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_id;
          last_id_d  = pick_id;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        // Handover loads the next winner directly, so back-to-back bursts have no bubble.
        if (release_burst) begin
          beat_cnt_d = '0;
          if (pick_found) begin
            grant_id_d = pick_id;
            last_id_d  = pick_id;
          end else begin
            state_d    = ARB_IDLE;
            grant_id_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a queue-based round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int EXP_GAP_GRANT = 0;
`else
  localparam int EXP_GAP_GRANT = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic          full, wr_en, busy;
  logic [DW-1:0] wr_data;
  logic [1:0]    grant_id;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [8:0] src_q [N][$];   // {last, data} per requester
  logic [N-1:0] en;
  int         beat_src [$];
  int         beat_cyc [$];
  int         m_owner, m_last, m_beats;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic drive();
    logic [8:0] w;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        w = src_q[i][0];
        req_valid[i]         = en[i];
        req_data[i*DW +: DW] = w[7:0];
        req_last[i]          = w[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    logic [N-1:0] v, l, exp_oh;
    logic         exp_busy, exp_wr, rel;
    logic [8:0]   head;
    int           p;
    v        = req_valid;
    l        = req_last;
    exp_busy = (m_owner >= 0);
    exp_oh   = '0;
    exp_wr   = 1'b0;
    if (exp_busy) begin
      exp_oh[m_owner] = 1'b1;
      exp_wr = v[m_owner] && !full;
    end
    check("busy", 64'(busy), 64'(exp_busy));
    check("grant", 64'(grant), 64'(exp_oh));
    if (exp_busy) check("grant_id", 64'(grant_id), 64'(m_owner));
    check("wr_en", 64'(wr_en), 64'(exp_wr));
    check("req_ready", 64'(req_ready), exp_wr ? 64'(exp_oh) : 64'(0));
    if (exp_wr) begin
      head = src_q[m_owner][0];
      check("wr_data", 64'(wr_data), 64'(head[7:0]));
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1 && src_q[i].size() > 0) begin
        beat_src.push_back(i);
        beat_cyc.push_back(cyc);
        void'(src_q[i].pop_front());
      end
    end
    if (!exp_busy) begin
      p = rr_next(v, m_last);
      if (p >= 0) begin m_owner = p; m_last = p; m_beats = 0; end
    end else begin
      rel = 1'b0;
      if (exp_wr) begin
        m_beats++;
        rel = l[m_owner] || (m_beats == MB);
      end
`ifndef FIFO_ARB_BURST_LOCK_EN
      if (!v[m_owner]) rel = 1'b1;
`endif
      if (rel) begin
        p = rr_next(v, m_owner);
        if (p >= 0) begin m_owner = p; m_last = p; end
        else m_owner = -1;
        m_beats = 0;
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic f);
    full = f;
    drive();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    int left;
    left = pending();
    while (left > 0 && n < budget) begin
      if (rnd) begin
        for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
        cycle($urandom_range(0, 3) == 0);
      end else begin
        en = '1;
        cycle(1'b0);
      end
      n++;
      left = pending();
    end
    check("drain_left", 64'(left), 64'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic push_words(input int id, input int len, input int tag);
    for (int k = 0; k < len; k++) src_q[id].push_back({(k == len - 1), 8'(tag + k)});
  endtask

  initial begin
    int base, c0, b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full      = 1'b0;
    en        = '1;

    // Single requester: 5 words 0..4, last on the fifth.
    do_reset();
    push_words(0, 5, 0);
    base = beat_src.size();
    c0   = cyc;
    drain(50, 1'b0);
    cycle(1'b0);
    check("s1_beats", 64'(beat_src.size() - base), 64'(5));
    if (beat_src.size() >= base + 5) begin
      check("s1_first_latency", 64'(beat_cyc[base] - c0), 64'(1));
      check("s1_span", 64'(beat_cyc[base+4] - beat_cyc[base]), 64'(4));
    end
    check("s1_idle_after", 64'(busy), 64'(0));

    // Fairness: all four sources, three bursts of two each.
    do_reset();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < N; i++) push_words(i, 2, 16 * i + 2 * b);
    base = beat_src.size();
    drain(200, 1'b0);
    check("s2_beats", 64'(beat_src.size() - base), 64'(24));
    if (beat_src.size() >= base + 24) begin
      for (int k = 0; k < 24; k++) check("s2_order", 64'(beat_src[base+k]), 64'((k / 2) % N));
      check("s2_no_bubble", 64'(beat_cyc[base+23] - beat_cyc[base]), 64'(23));
    end

    // MAX_BURST: source 1 streams 40 words, source 2 competes.
    push_words(1, 40, 100);
    push_words(2, 5, 200);
    base = beat_src.size();
    drain(300, 1'b0);
    check("s3_beats", 64'(beat_src.size() - base), 64'(45));
    if (beat_src.size() >= base + 45) begin
      check("s3_beat16_src", 64'(beat_src[base+15]), 64'(1));
      check("s3_switch_src", 64'(beat_src[base+16]), 64'(2));
      check("s3_regrant_src", 64'(beat_src[base+21]), 64'(1));
    end

    // Full backpressure for 7 cycles in the middle of a 10-beat burst.
    push_words(3, 10, 50);
    base = beat_src.size();
    en   = '1;
    for (int k = 0; k < 4; k++) cycle(1'b0);
    b1 = beat_src.size();
    for (int k = 0; k < 7; k++) cycle(1'b1);
    check("s4_pre_full_beats", 64'(b1 - base), 64'(3));
    check("s4_beats_while_full", 64'(beat_src.size() - b1), 64'(0));
    drain(100, 1'b0);
    check("s4_beats", 64'(beat_src.size() - base), 64'(10));

    // Valid gap on the granted source while another source waits.
    push_words(0, 6, 10);
    push_words(1, 3, 30);
    for (int k = 0; k < 3; k++) cycle(1'b0);
    en[0] = 1'b0;
    cycle(1'b0);
    check("s5_gap_grant_id", 64'(grant_id), 64'(EXP_GAP_GRANT));
    cycle(1'b0);
    cycle(1'b0);
    drain(100, 1'b0);

    // Reset asserted mid-burst clears everything at once.
    push_words(2, 8, 70);
    for (int k = 0; k < 3; k++) cycle(1'b0);
    do_reset();
    cycle(1'b0);

    // Randomized bursts, valid gaps and full backpressure.
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < 6; b++) begin
        int len;
        len = $urandom_range(1, 20);
        for (int k = 0; k < len; k++)
          src_q[i].push_back({(k == len - 1) || ($urandom_range(0, 9) < 3), 8'($urandom)});
      end
    end
    drain(6000, 1'b1);
    en = '1;
    for (int k = 0; k < 3; k++) cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
